id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS core.
- Consumes the decoded control bits from the decode control unit plus register-file read data, immediate and register specifiers.
- Registers them for the EX stage and selects the write-destination register.
- Contains load-use hazard detection: it inserts a bubble and asserts a stall to PC/IF-ID; branch flush takes priority.

Parameters:
- DATA_W, 32, width of register data, immediate and PC.
- REG_W, 5, register specifier width.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset. One clock domain; reset asserts asynchronously.
- id_valid  in  1  IF/ID holds a real instruction.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  in  1 each  control bits from decode.
- id_alu_op  in  2  ALUOp from decode: 00 add, 01 sub/BEQ, 10 R-type funct.
- id_rd1, id_rd2  in  DATA_W  register-file read data for rs, rt.
- id_imm  in  DATA_W  sign-extended immediate.
- id_pc4  in  DATA_W  PC+4 of the instruction.
- id_rs, id_rt, id_rd  in  REG_W  instruction register fields.
- id_funct  in  6  funct field.
- flush  in  1  branch taken / redirect; kill the instruction entering EX.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1 each  registered control.
- ex_alu_op  out  2  registered ALUOp.
- ex_rd1, ex_rd2, ex_imm, ex_pc4  out  DATA_W  registered data.
- ex_rs, ex_rt, ex_wreg  out  REG_W  registered specifiers; ex_wreg is the write destination.
- ex_funct  out  6  registered funct.

Behaviour:
- Reset (rst_n=0, asynchronous): every ex_* output = 0, so ex_valid=0 and all control is 0 (NOP bubble). stall=0 while in reset.
- Latency: one cycle; the ID inputs sampled at a rising edge appear on ex_* after that edge.
- Destination: wreg_next = (id_alu_op==2'b10) ? id_rd : id_rt.
- uses_rt = !id_alu_src || id_mem_write. This is true for R-type, SW and BEQ, and false for LW.
- Load-use hazard (hz), all of the following true:
  - ex_valid && ex_mem_read && id_valid && ex_wreg!=0, and
  - (ex_wreg==id_rs || (uses_rt && ex_wreg==id_rt)).
- stall = hz && !flush.
- Per-edge update, priority order:
  - (1) flush=1: load bubble. ex_valid and all control bits go to 0; data/specifier fields may load the ID values (don't-care). stall=0 the same cycle.
  - (2) hz=1: load bubble, same as (1). Upstream holds, so the ID instruction is re-presented next cycle.
  - (3) id_valid=0: load bubble.
  - (4) otherwise: load all ID values; ex_valid=1.
- A bubble guarantees ex_reg_write=ex_mem_write=ex_mem_read=0; downstream stages rely on this.
- Register $0: a load to $0 never stalls.
- Back-to-back loads: the second load stalls only if it depends on the first.
- Stall duration: a stall lasts exactly one cycle. After the bubble, ex_mem_read=0, so hz clears and the dependent instruction enters EX.
- Reset mid-stall: outputs clear immediately; stall drops in the same cycle because ex_valid=0.
- No X on outputs after reset regardless of input values.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined:
  - Adds output stall_cnt (CNT_W) and output flush_cnt (CNT_W).
  - stall_cnt increments on each edge where stall=1; flush_cnt on each edge where flush=1.
  - Both counters saturate at all-ones and reset to 0 with rst_n.
- When undefined: the ports and the logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_n=0 mid-run with ex_valid=1 -> all ex_* = 0 and stall=0 immediately, without waiting for a clock edge.
- R-type pass-through: id_alu_op=10, rs=1, rt=2, rd=3, rd1=0x11, rd2=0x22, reg_write=1 -> next cycle ex_wreg=3, ex_rd1=0x11, ex_rd2=0x22, ex_valid=1, stall=0.
- Load-use: LW $5 in EX, then ADD $6,$5,$7 in ID -> stall=1 for one cycle and a bubble enters EX (ex_valid=0, ex_reg_write=0); the next cycle ADD enters EX with ex_rs=5.
- No false stall, three cases:
  - LW $5 followed by LW $8,0($9) -> stall=0.
  - LW $5 followed by LW $5,0($9): rt=5 but uses_rt=0 -> stall=0.
  - LW $0 followed by ADD using $0 -> stall=0.
- Flush priority: hazard condition true and flush=1 in the same cycle -> stall=0 and a bubble is loaded. With ID_EX_PERF_CNT_EN: flush_cnt increments by 1 and stall_cnt is unchanged.
- Counter saturation (ID_EX_PERF_CNT_EN, CNT_W=4): 20 stall cycles -> stall_cnt=15 and holds there.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register of the 5-stage MIPS core. Registers
//               decoded control, register-file data, immediate, PC+4 and
//               register specifiers for EX, selects the write destination,
//               and detects load-use hazards (bubble into EX + stall to
//               PC/IF-ID). A branch flush overrides the hazard.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : DATA_W  data / immediate / PC width
//               REG_W   register specifier width
//               CNT_W   performance counter width
// Ports       : clk, rst_n (async active-low)
//               id_*    decoded instruction currently in IF/ID
//               flush   kill the instruction entering EX
//               stall   combinational hold request to PC and IF/ID
//               ex_*    registered instruction state for EX
//               stall_cnt, flush_cnt  (only with ID_EX_PERF_CNT_EN)
// Option      : `define ID_EX_PERF_CNT_EN adds saturating stall/flush
//               event counters.
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  input  logic [1:0]        id_alu_op,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [5:0]        id_funct,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic [1:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_wreg,
  output logic [5:0]        ex_funct
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  // Parameter sanity check at elaboration.
  if ((CNT_W < 1) || (REG_W < 1) || (DATA_W < 1)) begin : g_param_check
    $error("id_ex_stage: DATA_W, REG_W and CNT_W must all be >= 1");
  end

  // --------------------------------------------------------------------------
  // Pipeline register state
  // --------------------------------------------------------------------------
  logic              valid_q,      valid_d;
  logic              reg_write_q,  reg_write_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_write_q,  mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              alu_src_q,    alu_src_d;
  logic [1:0]        alu_op_q,     alu_op_d;
  logic [DATA_W-1:0] rd1_q,        rd1_d;
  logic [DATA_W-1:0] rd2_q,        rd2_d;
  logic [DATA_W-1:0] imm_q,        imm_d;
  logic [DATA_W-1:0] pc4_q,        pc4_d;
  logic [REG_W-1:0]  rs_q,         rs_d;
  logic [REG_W-1:0]  rt_q,         rt_d;
  logic [REG_W-1:0]  wreg_q,       wreg_d;
  logic [5:0]        funct_q,      funct_d;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  logic uses_rt;
  logic hz;
  logic bubble;

  always_comb begin
    // LW only reads rs; R-type, SW and BEQ also read rt.
    uses_rt = !id_alu_src || id_mem_write;

    // A load in EX whose destination feeds the instruction in ID. $0 is
    // hard-wired, so a load targeting it never creates a dependency.
    hz = valid_q && mem_read_q && id_valid && (wreg_q != '0) &&
         ((wreg_q == id_rs) || (uses_rt && (wreg_q == id_rt)));

    // A flush discards the ID instruction, so holding it would be pointless.
    stall  = hz && !flush;
    bubble = flush || hz || !id_valid;
  end

  // --------------------------------------------------------------------------
  // Next-state
  // --------------------------------------------------------------------------
  always_comb begin
    // Data and specifier fields always follow ID; they are don't-care in a
    // bubble because valid and all control bits are forced low.
    rd1_d   = id_rd1;
    rd2_d   = id_rd2;
    imm_d   = id_imm;
    pc4_d   = id_pc4;
    rs_d    = id_rs;
    rt_d    = id_rt;
    funct_d = id_funct;
    wreg_d  = (id_alu_op == ALU_OP_RTYPE) ? id_rd : id_rt;

    valid_d      = 1'b0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    alu_src_d    = 1'b0;
    alu_op_d     = 2'b00;

    if (!bubble) begin
      valid_d      = 1'b1;
      reg_write_d  = id_reg_write;
      mem_read_d   = id_mem_read;
      mem_write_d  = id_mem_write;
      mem_to_reg_d = id_mem_to_reg;
      alu_src_d    = id_alu_src;
      alu_op_d     = id_alu_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= 2'b00;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      pc4_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      wreg_q       <= '0;
      funct_q      <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= alu_src_d;
      alu_op_q     <= alu_op_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      pc4_q        <= pc4_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      wreg_q       <= wreg_d;
      funct_q      <= funct_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_alu_src    = alu_src_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_rd1        = rd1_q;
  assign ex_rd2        = rd2_q;
  assign ex_imm        = imm_q;
  assign ex_pc4        = pc4_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_wreg       = wreg_q;
  assign ex_funct      = funct_q;

`ifdef ID_EX_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating event counters
  // --------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (flush && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire
